// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types and constants for the shared-shifter arbiter:
//                operand widths, direction encodings and the request bundle
//                handed from the arbiter to the shift core.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    // Operand bundle of the current winner: {data, shift, dir}
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shift;
        logic               dir;
    } shift_req_t;

endpackage
`default_nettype wire

// File: rtl/shift8_core.sv
`default_nettype none
// ============================================================================
//  Module      : shift8_core
//  Description : Combinational 8-bit logical shifter with zero fill.
//                dir = SHIFT_LEFT shifts toward the MSB, SHIFT_RIGHT toward
//                the LSB; a shift amount of 0 passes the data through.
//  Ports       : req    - operand bundle {data, shift, dir}
//                result - shifted data
//  Revision    : 1.0  initial release
// ============================================================================
module shift8_core
    import shift_pkg::*;
(
    input  shift_req_t          req,
    output logic [DATA_W-1:0]   result
);

    always_comb begin
        result = '0;
        case (req.dir)
            SHIFT_LEFT:  result = req.data << req.shift;
            SHIFT_RIGHT: result = req.data >> req.shift;
            default:     result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter
//  Description : Round-robin arbiter sharing one 8-bit shifter between NREQ
//                valid/ready requesters. The winner's result is captured in a
//                single registered, back-pressurable output stage tagged with
//                the requester index.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                req_valid/req_ready    - per-requester handshake
//                req_data/shift/dir     - packed per-requester operands
//                out_valid/ready        - result handshake
//                out_data, out_id       - result and originating requester
//                op_count               - results accepted downstream (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [DATA_W*NREQ-1:0]  req_data,
    input  logic [SHAMT_W*NREQ-1:0] req_shift,
    input  logic [NREQ-1:0]         req_dir,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDW-1:0]          out_id,
    input  logic                    out_ready,
    output logic [CNTW-1:0]         op_count
);

    typedef struct packed {
        logic           found;
        logic [IDW-1:0] idx;
    } pick_t;

    // First valid requester scanning upward from ptr, wrapping at NREQ.
    // Iterating from the far end lets the closest candidate overwrite the rest.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] valid,
                                      input logic [IDW-1:0]  ptr);
        pick_t p;
        int    j;
        p = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (valid[j]) begin
                p.found = 1'b1;
                p.idx   = IDW'(j);
            end
        end
        return p;
    endfunction

    logic [IDW-1:0]    r_rr_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [IDW-1:0]    r_out_id;
    logic [CNTW-1:0]   r_op_count;

    pick_t             w_pick;
    logic              w_can_accept;
    logic [NREQ-1:0]   w_ready;
    logic              w_xfer;
    logic [IDW-1:0]    w_next_ptr;
    shift_req_t        w_win_req;
    logic [DATA_W-1:0] w_result;

    assign w_pick       = rr_pick(req_valid, r_rr_ptr);
    assign w_can_accept = !r_out_valid || out_ready;

    // Grant strobe is suppressed during reset so no requester believes a
    // transfer happened on an edge that the register will ignore.
    always_comb begin
        w_ready = '0;
        if (!rst && w_pick.found && w_can_accept) begin
            w_ready[w_pick.idx] = 1'b1;
        end
    end

    assign w_xfer     = |w_ready;
    assign w_next_ptr = (w_pick.idx == IDW'(NREQ - 1)) ? '0 : w_pick.idx + 1'b1;

    // Only the winner's operands reach the single shared shifter.
    always_comb begin
        w_win_req       = '0;
        w_win_req.data  = req_data[w_pick.idx * DATA_W +: DATA_W];
        w_win_req.shift = req_shift[w_pick.idx * SHAMT_W +: SHAMT_W];
        w_win_req.dir   = req_dir[w_pick.idx];
    end

    shift8_core u_shift8_core (
        .req    (w_win_req),
        .result (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_op_count  <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_op_count <= r_op_count + 1'b1;
            end
            // A new load takes priority over a drain so the stage can refill
            // in the same cycle it empties.
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
                r_out_id    <= w_pick.idx;
                r_rr_ptr    <= w_next_ptr;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_arbiter
//  Description : Self-checking bench for shift_arbiter. A negedge monitor
//                keeps a reference round-robin pointer and a result queue;
//                scenario tasks add directed inline checks. A second instance
//                with a 4-bit counter shares the stimulus to exercise wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_arbiter;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [11:0] req_shift = '0;
    logic [3:0]  req_dir   = '0;
    logic        out_ready = 1'b1;
    logic [3:0]  req_ready, req_ready4;
    logic        out_valid, out_valid4;
    logic [7:0]  out_data, out_data4;
    logic [1:0]  out_id, out_id4;
    logic [15:0] op_count;
    logic [3:0]  op_count4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_shift(req_shift), .req_dir(req_dir), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .op_count(op_count)
    );

    shift_arbiter #(.NREQ(4), .IDW(2), .CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_shift(req_shift), .req_dir(req_dir), .req_ready(req_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_id(out_id4),
        .out_ready(out_ready), .op_count(op_count4)
    );

    // Reference shifter: one bit position per step, zero fill.
    function automatic logic [7:0] ref_shift(input logic [7:0] d,
                                             input logic [2:0] s,
                                             input logic dir);
        logic [7:0] v;
        v = d;
        for (int k = 0; k < int'(s); k++) begin
            if (dir) v = {1'b0, v[7:1]};
            else     v = {v[6:0], 1'b0};
        end
        return v;
    endfunction

    task automatic set_req(input int i, input logic [7:0] d,
                           input logic [2:0] s, input logic dir);
        req_data[8*i +: 8]  = d;
        req_shift[3*i +: 3] = s;
        req_dir[i]          = dir;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
    endtask

    // ---------------- scoreboard monitor ----------------
    sb_t         sbq[$];
    sb_t         m_item;
    int          m_ptr = 0;
    int          m_win;
    bit          m_found;
    logic [3:0]  m_exp_ready;
    logic [15:0] m_cnt  = '0;
    logic [3:0]  m_cnt4 = '0;

    always @(negedge clk) begin
        if (rst) begin
            n_tests++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL mon_ready_in_rst: got %b want 0000", req_ready);
            end
            sbq.delete();
            m_ptr  = 0;
            m_cnt  = '0;
            m_cnt4 = '0;
        end else begin
            m_exp_ready = '0;
            m_found     = 1'b0;
            m_win       = 0;
            if (sbq.size() == 0 || out_ready) begin
                for (int k = 0; k < 4; k++) begin
                    if (!m_found && req_valid[(m_ptr + k) % 4]) begin
                        m_found = 1'b1;
                        m_win   = (m_ptr + k) % 4;
                        m_exp_ready[m_win] = 1'b1;
                    end
                end
            end
            n_tests++;
            if (req_ready !== m_exp_ready) begin
                n_fail++;
                $display("FAIL mon_req_ready: got %b want %b", req_ready, m_exp_ready);
            end
            n_tests++;
            if (out_valid !== (sbq.size() != 0)) begin
                n_fail++;
                $display("FAIL mon_out_valid: got %b want %b", out_valid, sbq.size() != 0);
            end
            if (sbq.size() != 0) begin
                n_tests++;
                if (out_data !== sbq[0].data || out_id !== sbq[0].id) begin
                    n_fail++;
                    $display("FAIL mon_result: got id %0d data %h want id %0d data %h",
                             out_id, out_data, sbq[0].id, sbq[0].data);
                end
            end
            n_tests++;
            if (op_count !== m_cnt || op_count4 !== m_cnt4) begin
                n_fail++;
                $display("FAIL mon_op_count: got %0d/%0d want %0d/%0d",
                         op_count, op_count4, m_cnt, m_cnt4);
            end
            if (sbq.size() != 0 && out_ready) begin
                void'(sbq.pop_front());
                m_cnt  = m_cnt + 1'b1;
                m_cnt4 = m_cnt4 + 1'b1;
            end
            if (m_found) begin
                m_item.id   = 2'(m_win);
                m_item.data = ref_shift(req_data[8*m_win +: 8],
                                        req_shift[3*m_win +: 3], req_dir[m_win]);
                sbq.push_back(m_item);
                m_ptr = (m_win + 1) % 4;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0 || op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v%b d%h id%0d cnt%0d want all zero",
                     out_valid, out_data, out_id, op_count);
        end
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single_op();
        out_ready = 1'b1;
        set_req(0, 8'hB5, 3'd3, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA8 || out_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_result: got v%b d%h id%0d want v1 dA8 id0",
                     out_valid, out_data, out_id);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (op_count !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count: got cnt%0d v%b want cnt1 v0", op_count, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_corners();
        set_req(2, 8'h81, 3'd7, 1'b1);
        req_valid = 4'b0100;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL corner_ready2: got %b want 0100", req_ready);
        end
        @(posedge clk); #1;
        set_req(1, 8'h5A, 3'd0, 1'b0);
        req_valid = 4'b0010;
        @(negedge clk);
        n_tests++;
        if (out_data !== 8'h01 || out_id !== 2'd2) begin
            n_fail++;
            $display("FAIL corner_right7: got d%h id%0d want d01 id2", out_data, out_id);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (out_data !== 8'h5A || out_id !== 2'd1) begin
            n_fail++;
            $display("FAIL corner_shift0: got d%h id%0d want d5A id1", out_data, out_id);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [3:0] granted;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) rand_req(i);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            granted = req_ready;
            n_tests++;
            if (granted !== (4'b0001 << (k % 4))) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %b want %b", k, granted, 4'b0001 << (k % 4));
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (granted[i]) rand_req(i);
        end
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (op_count !== 16'd8) begin
            n_fail++;
            $display("FAIL rr_count: got %0d want 8", op_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp1, exp3;
        do_reset();
        out_ready = 1'b0;
        rand_req(1);
        rand_req(3);
        exp1 = ref_shift(req_data[15:8], req_shift[5:3], req_dir[1]);
        exp3 = ref_shift(req_data[31:24], req_shift[11:9], req_dir[3]);
        req_valid = 4'b1010;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_first_grant: got %b want 0010", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp1 || out_id !== 2'd1 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v%b d%h id%0d rdy%b want v1 d%h id1 rdy0000",
                         k, out_valid, out_data, out_id, req_ready, exp1);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b1000 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got rdy%b v%b want rdy1000 v1", req_ready, out_valid);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== exp3) begin
            n_fail++;
            $display("FAIL bp_refill: got v%b id%0d d%h want v1 id3 d%h",
                     out_valid, out_id, out_data, exp3);
        end
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        rand_req(2);
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) begin
            n_fail++;
            $display("FAIL rmid_loaded: got v%b id%0d want v1 id2", out_valid, out_id);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        rand_req(0);
        rand_req(3);
        req_valid = 4'b1001;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || op_count !== 16'd0 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rmid_after: got v%b cnt%0d rdy%b want v0 cnt0 rdy0001",
                     out_valid, op_count, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b1000;
        @(negedge clk);
        n_tests++;
        if (out_id !== 2'd0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_grant0: got id%0d rdy%b want id0 rdy0000", out_id, req_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_counter_wrap();
        bit seen15 = 0;
        bit wrapped = 0;
        do_reset();
        out_ready = 1'b1;
        rand_req(0);
        req_valid = 4'b0001;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (op_count4 == 4'd15) seen15 = 1;
            if (seen15 && op_count4 == 4'd0) wrapped = 1;
            @(posedge clk); #1;
            if (k == 16) req_valid = '0;
            else rand_req(0);
        end
        @(negedge clk);
        n_tests++;
        if (op_count4 !== 4'd1 || op_count !== 16'd17) begin
            n_fail++;
            $display("FAIL wrap_final: got %0d/%0d want 1/17", op_count4, op_count);
        end
        n_tests++;
        if (!(seen15 && wrapped)) begin
            n_fail++;
            $display("FAIL wrap_sequence: got seen15=%0d wrapped=%0d want 1/1", seen15, wrapped);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_corners();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_counter_wrap();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one 8-bit logical shift datapath between NREQ independent requesters. Arbitration is round-robin. Each requester has a valid/ready request channel. Results leave through a single registered, back-pressurable output channel tagged with the requester ID. The block sits between the per-lane control FSMs and the shared shift resource, so several lanes can use one shifter without a per-lane copy.

Parameters:
NREQ, 4, number of requesters; legal range 2..8.
IDW, 2, width of requester ID; must equal ceil(log2(NREQ)).
CNTW, 16, width of the completed-operation counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  NREQ  per-requester request valid.
req_data  input  8*NREQ  operand; slice i = bits [8i+7:8i].
req_shift  input  3*NREQ  shift amount 0..7; slice i = bits [3i+2:3i].
req_dir  input  NREQ  direction per requester; 0 = left, 1 = right.
req_ready  output  NREQ  one-hot-or-zero accept strobe; combinational.
out_valid  output  1  result valid; registered.
out_data  output  8  shifted result; registered.
out_id  output  IDW  index of the requester that produced out_data; registered.
out_ready  input  1  downstream accepts the result.
op_count  output  CNTW  number of results accepted downstream; wraps.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - out_valid=0, out_data=0, out_id=0, op_count=0;
  - rr_ptr=0, where rr_ptr is the index with highest priority.
  - Any result held in the output register is discarded.
  - req_ready is 0 for the whole cycle while rst=1.
- Shift function, zero fill:
  - dir=0: out = data << shift, truncated to 8 bits.
  - dir=1: out = data >> shift, truncated to 8 bits.
  - shift=0 passes data unchanged.
- can_accept = !out_valid || out_ready.
- Arbitration is combinational each cycle:
  - Scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first i with req_valid[i]=1 is the winner.
  - req_ready[winner] = can_accept. All other req_ready bits are 0.
  - No request valid: req_ready = 0.
- Transfer occurs when req_valid[i] && req_ready[i]. At that clk edge:
  - out_data and out_id are loaded, and out_valid=1.
  - rr_ptr = (i+1) mod NREQ.
  - Latency is exactly 1 cycle from the transfer to out_valid.
- Output hold: while out_valid && !out_ready, out_data, out_id and out_valid are stable and req_ready=0.
- Simultaneous drain and fill (out_valid && out_ready && a new transfer in the same cycle):
  - The register loads the new result; out_valid stays 1.
  - Full throughput is 1 op/cycle.
- Drain with no new transfer: out_valid goes to 0 on the next edge.
- op_count increments by 1 on each cycle with out_valid && out_ready. It wraps from 2^CNTW-1 to 0.
- rr_ptr does not move when no transfer occurs.
  - Fairness: a continuously-valid requester is granted within NREQ transfers.
- Requester protocol: once req_valid[i] is raised, it holds req_valid[i], req_data and req_shift/req_dir slices stable until req_ready[i]. Behaviour is undefined otherwise.
- No combinational path from req_* to out_*. The only combinational paths are req_valid/out_ready -> req_ready.

Decomposition:
- Shared package shift_pkg:
  - SHIFT_LEFT=1'b0 and SHIFT_RIGHT=1'b1 constants.
  - Typedef shift_req_t = {data[7:0], shift[2:0], dir}.
  - DATA_W=8 and SHAMT_W=3.
- One sub-module: shift8_core. It is the combinational 8-bit zero-fill left/right shifter, instantiated once on the winner's operands.
- Round-robin pick logic stays in the top module as a function.

Test Plan:
- Single op: rst, then req0 valid with data=8'hB5, shift=3, dir=0, out_ready=1 -> req_ready=4'b0001 that cycle; next cycle out_valid=1, out_data=8'hA8, out_id=0, op_count=1.
- Right shift and shift-0 corners: req2 with 8'h81, shift=7, dir=1 -> 8'h01. Req1 with 8'h5A, shift=0 -> 8'h5A, out_id=1.
- Round-robin: all 4 requesters valid continuously, out_ready=1 -> grants in order 0,1,2,3,0,… one per cycle; op_count=8 after 8 result cycles.
- Back-pressure: out_ready=0 for 5 cycles with req1 and req3 valid -> out_data/out_id frozen and req_ready=0. When out_ready=1, the held result drains and the next grant goes in the same cycle (out_valid never drops).
- Reset mid-operation: out_valid=1 and out_ready=0, then assert rst for 1 cycle -> out_valid=0, op_count=0. Next grant goes to req0 if valid, even though rr_ptr was nonzero before reset.
- Counter wrap: with CNTW=4, complete 17 ops -> op_count sequence reaches 15 and then 0, and reads 1 after the 17th.
